// File: rtl/keypad_pkg.sv
// Purpose : shared keypad geometry, key-code types and the pending-key priority encoder.
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int KEY_NUM    = KEY_ROWS * KEY_COLS;

  typedef logic [KEY_CODE_W-1:0] key_code_t;
  typedef logic [KEY_NUM-1:0]    key_vec_t;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on |v).
  function automatic key_code_t lowest_key(input key_vec_t v);
    key_code_t idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// Purpose : keypad matrix lines plus the CPU-side key read port, bundled as one interface.
// Latency : n/a (wires only).
// Backpressure: none on the keypad side; the CPU paces reads with pop.
// Ports   : rows (row drive, active-low), cols (column sense, active-low), pop,
//           clear_overflow, key_code (head entry), key_valid, overflow, count.
interface keypad_scan_fifo_if
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [KEY_ROWS-1:0] rows;
  logic [KEY_COLS-1:0] cols;
  logic                pop;
  logic                clear_overflow;
  key_code_t           key_code;
  logic                key_valid;
  logic                overflow;
  logic [CNT_W-1:0]    count;

  // master: the keypad/CPU side; slave: the scanner.
  modport master (
    input  rows, key_code, key_valid, overflow, count,
    output cols, pop, clear_overflow
  );

  modport slave (
    output rows, key_code, key_valid, overflow, count,
    input  cols, pop, clear_overflow
  );

endinterface

// File: rtl/keypad_scan_fifo_sync_fifo.sv
// Purpose : generic circular-buffer FIFO with occupancy count; head is 0 when empty.
// Latency : push visible on head/count one clk edge after the push cycle.
// Backpressure: push while full is dropped unless a pop is accepted in the same cycle.
// Ports   : clk, reset, push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o, count_o.
module sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // A pop on an empty FIFO is ignored, so an empty push+pop keeps the push.
  // A full push is accepted only when a real pop frees the slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/keypad_scan_fifo.sv
// Purpose : scans a 4x4 keypad, debounces all keys per frame, queues press events as key codes.
// Latency : event pushed the cycle after the debouncing frame end; visible one edge later.
// Backpressure: CPU pops one code per pop strobe; events arriving while full are dropped (overflow).
// Ports   : clk, reset (async, active-high), bus (keypad_scan_fifo_if.slave: rows, cols, pop,
//           clear_overflow, key_code, key_valid, overflow, count).
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  keypad_scan_fifo_if.slave   bus
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int ROW_W   = $clog2(KEY_ROWS);
  localparam int STAB_W  = $clog2(DEBOUNCE_SCANS + 1);

  // Column synchronizer; idle (pulled-up) value is all ones.
  logic [KEY_COLS-1:0] col_s1_q, col_s2_q;

  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic                sample, frame_end;

  key_vec_t            frame_q, frame_d;
  key_vec_t            last_frame_q, last_frame_d;
  key_vec_t            debounced_q, debounced_d;
  key_vec_t            pending_q, pending_d;
  key_vec_t            new_press;
  logic [STAB_W-1:0]   stable_cnt_q, stable_cnt_d;

  logic                push_vld;
  key_code_t           push_code;
  logic                fifo_full, fifo_empty, drop;
  logic                overflow_q, overflow_d;

  // Sampling at the last dwell cycle leaves SCAN_DIV-1 cycles for the columns to settle.
  assign sample    = (dwell_q == DWELL_W'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx_q == ROW_W'(KEY_ROWS - 1));

  always_comb begin
    dwell_d   = dwell_q + DWELL_W'(1);
    row_idx_d = row_idx_q;
    frame_d   = frame_q;
    if (sample) begin
      dwell_d   = '0;
      row_idx_d = (row_idx_q == ROW_W'(KEY_ROWS - 1)) ? '0 : row_idx_q + ROW_W'(1);
      frame_d[row_idx_q*KEY_COLS +: KEY_COLS] = ~col_s2_q;
    end
  end

  // Debounce on whole frames: a key state only changes after DEBOUNCE_SCANS identical frames.
  // frame_d already includes the row-3 sample taken on the frame-end cycle.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    last_frame_d = last_frame_q;
    debounced_d  = debounced_q;
    new_press    = '0;
    if (frame_end) begin
      if (frame_d == last_frame_q) begin
        if (stable_cnt_q != STAB_W'(DEBOUNCE_SCANS)) stable_cnt_d = stable_cnt_q + STAB_W'(1);
      end else begin
        stable_cnt_d = STAB_W'(1);
        last_frame_d = frame_d;
      end
      if (stable_cnt_d == STAB_W'(DEBOUNCE_SCANS)) begin
        // Only 0->1 transitions become events; releases just update the debounced view.
        new_press   = frame_d & ~debounced_q;
        debounced_d = frame_d;
      end
    end
  end

  // Drain one pending key per cycle, lowest code first.
  assign push_vld  = |pending_q;
  assign push_code = lowest_key(pending_q);

  always_comb begin
    pending_d = pending_q;
    if (push_vld) pending_d[push_code] = 1'b0;
    pending_d = pending_d | new_press;
  end

  // Matches the FIFO acceptance rule: full without a pop loses the entry.
  assign drop = push_vld && fifo_full && !bus.pop;

  always_comb begin
    overflow_d = overflow_q;
    if (bus.clear_overflow) overflow_d = 1'b0;
    if (drop)               overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1_q     <= '1;
      col_s2_q     <= '1;
      dwell_q      <= '0;
      row_idx_q    <= '0;
      frame_q      <= '0;
      last_frame_q <= '0;
      debounced_q  <= '0;
      stable_cnt_q <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      col_s1_q     <= bus.cols;
      col_s2_q     <= col_s1_q;
      dwell_q      <= dwell_d;
      row_idx_q    <= row_idx_d;
      frame_q      <= frame_d;
      last_frame_q <= last_frame_d;
      debounced_q  <= debounced_d;
      stable_cnt_q <= stable_cnt_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_vld),
    .push_dat_i (push_code),
    .pop_i      (bus.pop),
    .head_dat_o (bus.key_code),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (bus.count)
  );

  // Row drive follows row_idx directly so reset forces 1110 without waiting for a clock.
  assign bus.rows      = ~(KEY_ROWS'(1) << row_idx_q);
  assign bus.key_valid = !fifo_empty;
  assign bus.overflow  = overflow_q;

endmodule
